// File: rtl/time_counter.sv
// hh:mm:ss:cc time-of-day / countdown counter with run/pause, up/down, preset load,
// alarm compare and countdown-expired flag. Fields are 8-bit binary, stepped by a clock-enable divider.
module time_counter #(
  parameter int TICK_DIV = 500_000,
  parameter int DIV_W    = 20,
  parameter int HOURS    = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        dir,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        alarm_en,
  input  logic [31:0] alarm_time,
  output logic [31:0] time_data,
  output logic        tick,
  output logic        alarm_hit,
  output logic        expired
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       HH_MAX   = 8'(HOURS - 1);
  localparam logic [7:0]       MS_MAX   = 8'd59;
  localparam logic [7:0]       CC_MAX   = 8'd99;

  logic [DIV_W-1:0] div_q;
  logic [7:0]       hh, mm, ss, cc;
  logic [7:0]       nhh, nmm, nss, ncc;
  logic [7:0]       lhh, lmm, lss, lcc;
  logic [31:0]      next_time;
  logic             div_last;
  logic             step;

  assign time_data = {hh, mm, ss, cc};
  assign next_time = {nhh, nmm, nss, ncc};
  assign div_last  = (div_q == DIV_LAST);
  // Counting down from zero is suppressed entirely: no tick, no alarm, time holds.
  assign step      = run && div_last && !(dir && (time_data == 32'd0));

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nhh = hh;
    nmm = mm;
    nss = ss;
    ncc = cc;
    if (!dir) begin
      if (cc == CC_MAX) begin
        ncc = 8'd0;
        if (ss == MS_MAX) begin
          nss = 8'd0;
          if (mm == MS_MAX) begin
            nmm = 8'd0;
            nhh = (hh >= HH_MAX) ? 8'd0 : hh + 8'd1;
          end else begin
            nmm = mm + 8'd1;
          end
        end else begin
          nss = ss + 8'd1;
        end
      end else begin
        ncc = cc + 8'd1;
      end
    end else begin
      if (cc == 8'd0) begin
        ncc = CC_MAX;
        if (ss == 8'd0) begin
          nss = MS_MAX;
          if (mm == 8'd0) begin
            nmm = MS_MAX;
            nhh = (hh == 8'd0) ? HH_MAX : hh - 8'd1;
          end else begin
            nmm = mm - 8'd1;
          end
        end else begin
          nss = ss - 8'd1;
        end
      end else begin
        ncc = cc - 8'd1;
      end
    end
  end

  // Preset fields saturate at their maximum legal value.
  always_comb begin
    lhh = (load_data[31:24] > HH_MAX) ? HH_MAX : load_data[31:24];
    lmm = (load_data[23:16] > MS_MAX) ? MS_MAX : load_data[23:16];
    lss = (load_data[15:8]  > MS_MAX) ? MS_MAX : load_data[15:8];
    lcc = (load_data[7:0]   > CC_MAX) ? CC_MAX : load_data[7:0];
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      {hh, mm, ss, cc} <= 32'd0;
      tick      <= 1'b0;
      alarm_hit <= 1'b0;
      expired   <= 1'b0;
    end else begin
      tick      <= 1'b0;
      alarm_hit <= 1'b0;
      if (load) begin
        div_q   <= '0;
        {hh, mm, ss, cc} <= {lhh, lmm, lss, lcc};
        expired <= 1'b0;
      end else begin
        if (run) div_q <= div_last ? '0 : div_q + 1'b1;
        if (step) begin
          {hh, mm, ss, cc} <= next_time;
          tick      <= 1'b1;
          alarm_hit <= alarm_en && (next_time == alarm_time);
          if (dir && (next_time == 32'd0)) expired <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with TICK_DIV=4; a second HOURS=12 instance shares the inputs.
module tb_time_counter;

  logic        clk = 1'b0;
  logic        rst, run, dir, load, alarm_en;
  logic [31:0] load_data, alarm_time;
  logic [31:0] time_data, time_data12;
  logic        tick, alarm_hit, expired;
  logic        tick12, alarm_hit12, expired12;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  time_counter #(.TICK_DIV(4), .DIV_W(3), .HOURS(24)) dut (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .load(load), .load_data(load_data),
    .alarm_en(alarm_en), .alarm_time(alarm_time), .time_data(time_data),
    .tick(tick), .alarm_hit(alarm_hit), .expired(expired)
  );

  time_counter #(.TICK_DIV(4), .DIV_W(3), .HOURS(12)) dut12 (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .load(load), .load_data(load_data),
    .alarm_en(alarm_en), .alarm_time(alarm_time), .time_data(time_data12),
    .tick(tick12), .alarm_hit(alarm_hit12), .expired(expired12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] v);
    load_data = v;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  // Waits (bounded) for the next tick and checks how many clocks it took.
  task automatic wait_tick(input string tag, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 16);
    check({tag, "_tick"}, 32'(tick), 32'd1);
    check({tag, "_lat"}, n, exp_n);
  endtask

  task automatic count_ticks(input int n, output int t);
    t = 0;
    repeat (n) begin
      @(negedge clk);
      if (tick) t++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int hits;
    rst = 1'b1; run = 1'b0; dir = 1'b0; load = 1'b0; load_data = '0;
    alarm_en = 1'b0; alarm_time = '0;
    cycles(2);
    check("rst_time", time_data, 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_alarm", 32'(alarm_hit), 32'd0);
    check("rst_expired", 32'(expired), 32'd0);

    // Up counting from reset and the cc->ss carry
    rst = 1'b0; run = 1'b1;
    wait_tick("up1", 4);
    check("up1_val", time_data, 32'h0000_0001);
    cycles(1);
    check("tick_one_cycle", 32'(tick), 32'd0);
    wait_tick("up2", 3);
    check("up2_val", time_data, 32'h0000_0002);
    do_load(32'h0000_0063);
    check("load_63", time_data, 32'h0000_0063);
    check("load_no_tick", 32'(tick), 32'd0);
    wait_tick("cc_carry", 4);
    check("cc_carry_val", time_data, 32'h0000_0100);

    // Full wrap, 12-hour modulus and clamping
    do_load(32'h173B_3B63);
    wait_tick("wrap", 4);
    check("wrap24", time_data, 32'h0000_0000);
    check("wrap12_from_clamp", time_data12, 32'h0000_0000);
    check("tick12", 32'(tick12), 32'd1);
    check("alarm12_off", 32'(alarm_hit12), 32'd0);
    do_load(32'h0B3B_3B63);
    wait_tick("wrap_b", 4);
    check("hh_carry24", time_data, 32'h0C00_0000);
    check("wrap12", time_data12, 32'h0000_0000);
    do_load(32'hFFFF_FFFF);
    check("clamp24", time_data, 32'h173B_3B63);
    check("clamp12", time_data12, 32'h0B3B_3B63);
    do_load(32'h0A3C_0564);
    check("clamp_mixed", time_data, 32'h0A3B_0563);

    // Down counting and borrow chain
    dir = 1'b1;
    do_load(32'h0000_0100);
    wait_tick("dn1", 4);
    check("dn_borrow_ss", time_data, 32'h0000_0063);
    do_load(32'h0100_0000);
    wait_tick("dn2", 4);
    check("dn_borrow_hh", time_data, 32'h003B_3B63);
    check("dn_borrow_hh12", time_data12, 32'h003B_3B63);
    check("dn_not_expired", 32'(expired), 32'd0);
    check("dn_not_expired12", 32'(expired12), 32'd0);

    // Countdown to zero, expired, suppressed steps
    do_load(32'h0000_0002);
    wait_tick("cd1", 4);
    check("cd1_val", time_data, 32'h0000_0001);
    check("cd1_expired", 32'(expired), 32'd0);
    wait_tick("cd0", 4);
    check("cd0_val", time_data, 32'h0000_0000);
    check("cd0_expired", 32'(expired), 32'd1);
    count_ticks(12, t);
    check("zero_no_tick", t, 0);
    check("zero_hold", time_data, 32'h0000_0000);
    check("zero_expired", 32'(expired), 32'd1);
    dir = 1'b0;
    wait_tick("up_after_exp", 4);
    check("up_after_exp_val", time_data, 32'h0000_0001);
    check("expired_sticky", 32'(expired), 32'd1);
    do_load(32'h0000_0005);
    check("load_clears_exp", 32'(expired), 32'd0);
    check("load_5", time_data, 32'h0000_0005);

    // Alarm compare
    alarm_en = 1'b1; alarm_time = 32'h0000_0005;
    do_load(32'h0000_0000);
    for (int i = 1; i <= 5; i++) begin
      wait_tick($sformatf("al%0d", i), 4);
      check($sformatf("al%0d_hit", i), 32'(alarm_hit), 32'(i == 5));
    end
    check("al_val", time_data, 32'h0000_0005);
    cycles(1);
    check("al_one_cycle", 32'(alarm_hit), 32'd0);
    alarm_en = 1'b0;
    do_load(32'h0000_0000);
    hits = 0;
    for (int i = 1; i <= 5; i++) begin
      wait_tick($sformatf("aloff%0d", i), 4);
      if (alarm_hit) hits++;
    end
    check("al_disabled", hits, 0);
    alarm_en = 1'b1;
    do_load(32'h0000_0005);
    check("al_not_on_load", 32'(alarm_hit), 32'd0);

    // Pause keeps the partial period: divider holds at its last count before a step
    do_load(32'h0000_0000);
    cycles(3);
    run = 1'b0;
    count_ticks(10, t);
    check("pause_no_tick", t, 0);
    check("pause_hold", time_data, 32'h0000_0000);
    run = 1'b1;
    wait_tick("resume", 1);
    check("resume_val", time_data, 32'h0000_0001);

    // Load on the same edge as a step wins
    cycles(3);
    do_load(32'h0000_0042);
    check("ld_step_val", time_data, 32'h0000_0042);
    check("ld_step_tick", 32'(tick), 32'd0);
    wait_tick("after_ld_step", 4);
    check("after_ld_step_val", time_data, 32'h0000_0043);

    // Reset mid-period clears everything, including the divider
    dir = 1'b1;
    do_load(32'h0000_0001);
    wait_tick("pre_rst", 4);
    check("pre_rst_expired", 32'(expired), 32'd1);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("mid_rst_time", time_data, 32'd0);
    check("mid_rst_tick", 32'(tick), 32'd0);
    check("mid_rst_alarm", 32'(alarm_hit), 32'd0);
    check("mid_rst_expired", 32'(expired), 32'd0);
    dir = 1'b0;
    wait_tick("post_rst", 4);
    check("post_rst_val", time_data, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
